// File: rtl/fetch_decode_queue.sv
// Fetch-to-decode instruction queue: buffers {instr, pc2, err} words, absorbs decode stalls, flushes on redirect.
// Optional same-cycle bypass into an empty queue is enabled by defining FDQ_BYPASS_EN.
module fetch_decode_queue #(
  parameter int unsigned      DEPTH     = 2,
  parameter int unsigned      WIDTH     = 16,
  parameter logic [WIDTH-1:0] NOP_INSTR = WIDTH'(16'h0800)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     In_Valid,
  input  logic [WIDTH-1:0]         In_Instr,
  input  logic [WIDTH-1:0]         In_PC2,
  input  logic                     In_Err,
  input  logic                     Flush,
  input  logic                     Dec_Stall,
  output logic                     Full,
  output logic                     Out_Valid,
  output logic [WIDTH-1:0]         Out_Instr,
  output logic [WIDTH-1:0]         Out_PC2,
  output logic                     Out_Err,
  output logic [$clog2(DEPTH):0]   Count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [WIDTH-1:0] instr;
    logic [WIDTH-1:0] pc2;
    logic             err;
  } entry_t;

  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [CNT_W-1:0]   count;

  logic               empty;
  logic               push;
  logic               pop;
  logic               store;
  logic               advance;
  entry_t             head;
  entry_t             incoming;

  // Full depends only on registered count so fetch sees no input-to-stall path.
  assign Full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign Count    = count;
  assign incoming = '{instr: In_Instr, pc2: In_PC2, err: In_Err};

  // Head selection, handshake and storage control.
  always_comb begin
    push      = In_Valid & ~Full & ~Flush;
    head      = mem[rd_ptr];
    Out_Valid = ~empty;
`ifdef FDQ_BYPASS_EN
    if (empty && push) begin
      head      = incoming;
      Out_Valid = 1'b1;
    end
`endif
    pop       = Out_Valid & ~Dec_Stall;
    store     = push;
    advance   = pop;
`ifdef FDQ_BYPASS_EN
    // A bypassed word consumed immediately never occupies an entry.
    advance   = pop & ~empty;
    store     = push & ~(empty & pop);
`endif
    Out_Instr = Out_Valid ? head.instr : NOP_INSTR;
    Out_PC2   = Out_Valid ? head.pc2   : '0;
    Out_Err   = Out_Valid ? head.err   : 1'b0;
  end

  // Pointers and occupancy; flush realigns read to write without clearing data.
  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (Flush) begin
      count  <= '0;
      rd_ptr <= wr_ptr;
    end else begin
      if (store) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (advance) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(store) - CNT_W'(advance);
    end
  end

  // Entry storage needs no reset; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (store) begin
      mem[wr_ptr] <= incoming;
    end
  end

endmodule

// File: doc/fetch_decode_queue.md
Name: fetch_decode_queue

Overview:
Instruction buffer between the fetch stage and the decode stage. It captures the instruction, its PC+2 and the fetch error bit from fetch whenever the instruction memory delivers a word. It presents them to decode in order and absorbs decode back-pressure, so the instruction memory is never asked to re-fetch a completed word. On a redirect, a flush discards all buffered wrong-path instructions.

Parameters:
DEPTH, 2, number of queue entries; must be a power of two, 2 or 4.
WIDTH, 16, instruction and PC width in bits.
NOP_INSTR, 16'h0800, encoding driven on Out_Instr when no valid entry is presented.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
In_Valid  input  1  fetch has a completed instruction this cycle (memory done and not stalled).
In_Instr  input  WIDTH  instruction word from instruction memory.
In_PC2  input  WIDTH  PC+2 of that instruction.
In_Err  input  1  instruction memory error for that fetch.
Flush  input  1  branch/jump redirect (PC_Sel from execute); discard all contents.
Dec_Stall  input  1  decode cannot accept the head entry this cycle.
Full  output  1  queue holds DEPTH entries; fetch must hold its PC.
Out_Valid  output  1  head entry is valid.
Out_Instr  output  WIDTH  head instruction, or NOP_INSTR when not valid.
Out_PC2  output  WIDTH  head PC+2, or 0 when not valid.
Out_Err  output  1  head error bit, or 0 when not valid.
Count  output  $clog2(DEPTH)+1  number of valid entries.

Behaviour:
- State: DEPTH-entry storage {Instr, PC2, Err}, read pointer, write pointer, count. Pointers wrap modulo DEPTH.
- Reset (rst=1 at the edge): count=0, both pointers=0. Outputs after reset: Out_Valid=0, Out_Instr=NOP_INSTR, Out_PC2=0, Out_Err=0, Full=0, Count=0. Reset overrides Flush, push and pop.
- Full = (count==DEPTH). It is a function of registered state only, with no combinational path from any input.
- pop = Out_Valid & !Dec_Stall.
- push = In_Valid & !Full & !Flush. A push is refused while Full, even if a pop happens the same cycle. Fetch stalls on Full and re-presents the same word.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- Latency: a word pushed at edge N is visible on Out_* after edge N, i.e. one-cycle latency. Without the optional feature there is no bypass.
- Out_* come from the entry at the read pointer when count>0; otherwise they take the NOP/0 values above.
- Flush=1 at an edge: count=0, read pointer = write pointer (no data clear required), and the same-cycle push is dropped. The outputs show NOP from the next cycle on. Any pop in the flush cycle is irrelevant, because decode is also being flushed.
- Err is carried verbatim with its instruction. It is not sticky.
- In_Valid while Full: no state change; the word is lost unless fetch holds it. Fetch stalls on Full by contract.
- Dec_Stall while empty: no effect.

Optional Feature:
Macro FDQ_BYPASS_EN.
- Defined: when count==0 and push=1 and Flush=0, In_* drive Out_* combinationally in the same cycle and Out_Valid=1. If pop also occurs that cycle, the word is consumed and not stored (count stays 0). If Dec_Stall=1 that cycle, the word is stored normally. Latency is 0 cycles when empty.
- Undefined: no bypass; latency is always 1 cycle as above.

Test Plan:
1. Reset: hold rst=1 for 2 cycles with In_Valid=1 and In_Instr=16'h1234 -> Out_Valid=0, Out_Instr=16'h0800, Count=0, Full=0 after release.
2. Stream: push 16'hA001/PC2=2, 16'hA002/PC2=4, 16'hA003/PC2=6 on consecutive cycles with Dec_Stall=0 -> Out_Instr shows A001, A002, A003 on the next three cycles, Count stays ≤1, Full never asserts.
3. Back-pressure: Dec_Stall=1 while pushing 16'hB001 and 16'hB002 -> Count=2 and Full=1. A third push of 16'hB003 is refused. Release Dec_Stall -> B001, B002 drain in order; B003 is accepted once Full=0.
4. Flush: with the queue full (C001, C002), assert Flush together with In_Valid carrying 16'hC003 -> next cycle Count=0, Out_Valid=0, Out_Instr=16'h0800, and C003 never appears.
5. Wrap-around: 10 push/pop pairs with random Dec_Stall gaps, DEPTH=2 -> output order matches input order exactly; the PC2 and Err bits stay paired (inject In_Err=1 on the 7th word and see Out_Err=1 only with that word).
6. With FDQ_BYPASS_EN: empty queue, push 16'hD001 with Dec_Stall=0 -> Out_Valid=1 and Out_Instr=D001 in the same cycle, Count stays 0. Repeat with Dec_Stall=1 -> Count=1 after the edge.
